// File: rtl/loop_stack_ctrl.sv
// Nested hardware loop sequencer: decodes LOOPCOUNT/STARTLOOP/ENDLOOP and issues fetch redirects.
// Optional taken-redirect statistics counter is built when LOOP_STATS_EN is defined.
module loop_stack_ctrl #(
    parameter int PC_WIDTH  = 16,
    parameter int CNT_WIDTH = 16,
    parameter int DEPTH     = 4
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         INSTR_VALID,
    input  logic                         STALL,
    input  logic [31:0]                  INSTR,
    input  logic [PC_WIDTH-1:0]          PC,
    input  logic [CNT_WIDTH-1:0]         CNT_VAL,
    output logic                         REDIRECT,
    output logic [PC_WIDTH-1:0]          REDIRECT_PC,
    output logic [$clog2(DEPTH+1)-1:0]   LEVEL,
    output logic                         OVERFLOW,
    output logic                         UNDERFLOW,
    output logic [31:0]                  TOTAL_ITER
);
    localparam int LW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);

    localparam logic [7:0] OP_CNT_REG = 8'hD0;
    localparam logic [7:0] OP_CNT_IMM = 8'hD1;
    localparam logic [7:0] OP_START   = 8'hC0;
    localparam logic [7:0] OP_END     = 8'hC8;

    typedef struct packed {
        logic [PC_WIDTH-1:0]  start;
        logic [CNT_WIDTH-1:0] rem;
    } entry_t;

    entry_t               stack [DEPTH];
    logic [CNT_WIDTH-1:0] pending;
    logic                 accept;
    logic [7:0]           op;
    logic                 empty;
    logic                 full;
    logic [IW-1:0]        top_idx;
    logic [IW-1:0]        push_idx;
    entry_t               top;
    logic                 unused_instr;

    // The instruction presented while REDIRECT is high is wrong-path.
    assign accept       = INSTR_VALID & ~STALL & ~REDIRECT;
    assign op           = INSTR[31:24];
    assign empty        = (LEVEL == '0);
    assign full         = (LEVEL == LW'(DEPTH));
    assign top_idx      = empty ? '0 : IW'(LEVEL - LW'(1));
    assign push_idx     = IW'(LEVEL);
    assign top          = stack[top_idx];
    assign unused_instr = ^INSTR;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            REDIRECT    <= 1'b0;
            REDIRECT_PC <= '0;
            LEVEL       <= '0;
            OVERFLOW    <= 1'b0;
            UNDERFLOW   <= 1'b0;
            pending     <= CNT_WIDTH'(1);
            for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
        end else begin
            REDIRECT <= 1'b0;
            if (accept) begin
                unique case (op)
                    OP_CNT_IMM: pending <= INSTR[CNT_WIDTH-1:0];
                    OP_CNT_REG: pending <= CNT_VAL;
                    OP_START: begin
                        if (full) begin
                            OVERFLOW <= 1'b1;
                        end else begin
                            stack[push_idx] <= '{start: PC + PC_WIDTH'(1), rem: pending};
                            LEVEL           <= LEVEL + LW'(1);
                            pending         <= CNT_WIDTH'(1);
                        end
                    end
                    OP_END: begin
                        if (empty) begin
                            UNDERFLOW <= 1'b1;
                        end else if (top.rem > CNT_WIDTH'(1)) begin
                            stack[top_idx].rem <= top.rem - CNT_WIDTH'(1);
                            REDIRECT           <= 1'b1;
                            REDIRECT_PC        <= top.start;
                        end else begin
                            // Counts 0 and 1 both run the body once: just pop.
                            LEVEL <= LEVEL - LW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LOOP_STATS_EN
    logic [31:0] iter_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)         iter_cnt <= '0;
        else if (REDIRECT) iter_cnt <= iter_cnt + 32'd1;
    end

    assign TOTAL_ITER = iter_cnt;
`else
    assign TOTAL_ITER = 32'h0;
`endif

endmodule

// File: tb/tb_loop_stack_ctrl.sv
// Scoreboard bench for loop_stack_ctrl: expected redirect PCs queued per scenario, popped by a monitor.
module tb_loop_stack_ctrl;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        INSTR_VALID;
    logic        STALL;
    logic [31:0] INSTR;
    logic [15:0] PC;
    logic [15:0] CNT_VAL;
    logic        REDIRECT;
    logic [15:0] REDIRECT_PC;
    logic [2:0]  LEVEL;
    logic        OVERFLOW;
    logic        UNDERFLOW;
    logic [31:0] TOTAL_ITER;

    loop_stack_ctrl #(.PC_WIDTH(16), .CNT_WIDTH(16), .DEPTH(4)) dut (
        .CLK(CLK), .RESET(RESET), .INSTR_VALID(INSTR_VALID), .STALL(STALL),
        .INSTR(INSTR), .PC(PC), .CNT_VAL(CNT_VAL), .REDIRECT(REDIRECT),
        .REDIRECT_PC(REDIRECT_PC), .LEVEL(LEVEL), .OVERFLOW(OVERFLOW),
        .UNDERFLOW(UNDERFLOW), .TOTAL_ITER(TOTAL_ITER)
    );

    always #5 CLK = ~CLK;

    localparam logic [7:0] CNT_REG = 8'hD0;
    localparam logic [7:0] CNT_IMM = 8'hD1;
    localparam logic [7:0] START   = 8'hC0;
    localparam logic [7:0] ENDL    = 8'hC8;

`ifdef LOOP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] sb [$];
    logic [15:0] mon_exp;
    logic [31:0] pmem [32];

    // Every taken redirect must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (!RESET && REDIRECT) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL redirect_unexpected: got pc %0h, expected no redirect", REDIRECT_PC);
            end else begin
                mon_exp = sb.pop_front();
                if (REDIRECT_PC !== mon_exp) begin
                    n_err++;
                    $display("FAIL redirect_pc: got %0h, expected %0h", REDIRECT_PC, mon_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        RESET = 1'b1; INSTR_VALID = 1'b0; STALL = 1'b0; INSTR = '0; PC = '0; CNT_VAL = '0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic issue(input logic [7:0] op, input logic [23:0] lo, input logic [15:0] pc);
        int w = 0;
        @(negedge CLK);
        while (REDIRECT && w < 10) begin
            INSTR_VALID = 1'b0;
            w++;
            @(negedge CLK);
        end
        if (w >= 10) begin
            n_cmp++; n_err++;
            $display("FAIL issue_timeout: REDIRECT got stuck at 1, expected a single-cycle pulse");
        end
        INSTR_VALID = 1'b1; INSTR = {op, lo}; PC = pc;
    endtask

    task automatic idle();
        @(negedge CLK);
        INSTR_VALID = 1'b0;
    endtask

    // Fetch emulation: sequential PCs, follows REDIRECT, presents the wrong-path word during it.
    task automatic run(input int start_pc, input int end_pc, output int peak);
        int pc  = start_pc;
        int cyc = 0;
        peak = 0;
        forever begin
            @(negedge CLK);
            if (int'(LEVEL) > peak) peak = int'(LEVEL);
            cyc++;
            if (cyc > 300) begin
                n_cmp++; n_err++;
                $display("FAIL run_timeout: got %0d cycles, expected completion", cyc);
                INSTR_VALID = 1'b0;
                break;
            end
            if (REDIRECT) begin
                INSTR_VALID = 1'b1; INSTR = pmem[pc]; PC = 16'(pc);
                pc = int'(REDIRECT_PC);
            end else if (pc > end_pc) begin
                INSTR_VALID = 1'b0;
                break;
            end else begin
                INSTR_VALID = 1'b1; INSTR = pmem[pc]; PC = 16'(pc);
                pc++;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge CLK);
        n_cmp++; if (REDIRECT !== 1'b0) begin n_err++; $display("FAIL rst_redirect: got %0b, expected 0", REDIRECT); end
        n_cmp++; if (REDIRECT_PC !== 16'h0) begin n_err++; $display("FAIL rst_redirect_pc: got %0h, expected 0", REDIRECT_PC); end
        n_cmp++; if (LEVEL !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d, expected 0", LEVEL); end
        n_cmp++; if ({OVERFLOW, UNDERFLOW} !== 2'b00) begin n_err++; $display("FAIL rst_flags: got %b, expected 00", {OVERFLOW, UNDERFLOW}); end
        n_cmp++; if (TOTAL_ITER !== 32'h0) begin n_err++; $display("FAIL rst_total: got %0d, expected 0", TOTAL_ITER); end
    endtask

    task automatic test_single();
        int peak;
        do_reset();
        foreach (pmem[i]) pmem[i] = 32'h0;
        pmem[9]  = {CNT_IMM, 24'd3};
        pmem[10] = {START, 24'd0};
        pmem[13] = {ENDL, 24'd0};
        sb.push_back(16'd11); sb.push_back(16'd11);
        run(9, 13, peak);
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL single_missing: got %0d left, expected 0", sb.size()); end
        n_cmp++; if (LEVEL !== 3'd0) begin n_err++; $display("FAIL single_level: got %0d, expected 0", LEVEL); end
        n_cmp++; if (peak != 1) begin n_err++; $display("FAIL single_peak: got %0d, expected 1", peak); end
        n_cmp++; if (TOTAL_ITER !== (STATS ? 32'd2 : 32'd0)) begin n_err++; $display("FAIL single_total: got %0d, expected %0d", TOTAL_ITER, STATS ? 2 : 0); end
    endtask

    // Inner ENDLOOP at 8 is followed by outer ENDLOOP at 9, which is squashed during each inner redirect.
    task automatic test_nest();
        int peak;
        do_reset();
        CNT_VAL = 16'd3;
        foreach (pmem[i]) pmem[i] = 32'h0;
        pmem[3] = {CNT_IMM, 24'd2};
        pmem[4] = {START, 24'd0};
        pmem[5] = {CNT_REG, 4'h0, 4'h5, 16'h0};
        pmem[6] = {START, 24'd0};
        pmem[8] = {ENDL, 24'd0};
        pmem[9] = {ENDL, 24'd0};
        sb.push_back(16'd7); sb.push_back(16'd7); sb.push_back(16'd5);
        sb.push_back(16'd7); sb.push_back(16'd7);
        run(3, 9, peak);
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL nest_missing: got %0d left, expected 0", sb.size()); end
        n_cmp++; if (peak != 2) begin n_err++; $display("FAIL nest_peak: got %0d, expected 2", peak); end
        n_cmp++; if (LEVEL !== 3'd0) begin n_err++; $display("FAIL nest_level: got %0d, expected 0", LEVEL); end
        n_cmp++; if (TOTAL_ITER !== (STATS ? 32'd5 : 32'd0)) begin n_err++; $display("FAIL nest_total: got %0d, expected %0d", TOTAL_ITER, STATS ? 5 : 0); end
        CNT_VAL = 16'd0;
    endtask

    task automatic test_stack_limits();
        do_reset();
        for (int i = 0; i < 4; i++) issue(START, 24'd0, 16'(20 + i));
        idle();
        n_cmp++; if ({LEVEL, OVERFLOW} !== {3'd4, 1'b0}) begin n_err++; $display("FAIL full_no_ovf: got level %0d ovf %0b, expected 4 0", LEVEL, OVERFLOW); end
        issue(START, 24'd0, 16'd24);
        idle();
        n_cmp++; if (LEVEL !== 3'd4) begin n_err++; $display("FAIL ovf_level: got %0d, expected 4", LEVEL); end
        n_cmp++; if (OVERFLOW !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %0b, expected 1", OVERFLOW); end
        n_cmp++; if (UNDERFLOW !== 1'b0) begin n_err++; $display("FAIL ovf_unf: got %0b, expected 0", UNDERFLOW); end
        do_reset();
        issue(ENDL, 24'd0, 16'd2);
        idle();
        n_cmp++; if (UNDERFLOW !== 1'b1) begin n_err++; $display("FAIL unf_flag: got %0b, expected 1", UNDERFLOW); end
        n_cmp++; if (REDIRECT !== 1'b0) begin n_err++; $display("FAIL unf_redirect: got %0b, expected 0", REDIRECT); end
        n_cmp++; if ({LEVEL, OVERFLOW} !== {3'd0, 1'b0}) begin n_err++; $display("FAIL unf_state: got level %0d ovf %0b, expected 0 0", LEVEL, OVERFLOW); end
    endtask

    task automatic test_stall();
        do_reset();
        issue(CNT_IMM, 24'd2, 16'd19);
        issue(START, 24'd0, 16'd20);
        @(negedge CLK);
        STALL = 1'b1; INSTR_VALID = 1'b1; INSTR = {ENDL, 24'd0}; PC = 16'd22;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            n_cmp++; if ({REDIRECT, LEVEL} !== {1'b0, 3'd1}) begin n_err++; $display("FAIL stall_hold: got redirect %0b level %0d, expected 0 1", REDIRECT, LEVEL); end
        end
        sb.push_back(16'd21);
        STALL = 1'b0;
        @(negedge CLK);
        n_cmp++; if (REDIRECT !== 1'b1) begin n_err++; $display("FAIL stall_latency: got %0b, expected 1", REDIRECT); end
        STALL = 1'b1;
        @(negedge CLK);
        n_cmp++; if (REDIRECT !== 1'b0) begin n_err++; $display("FAIL redirect_under_stall: got %0b, expected 0", REDIRECT); end
        n_cmp++; if (LEVEL !== 3'd1) begin n_err++; $display("FAIL stall_level: got %0d, expected 1", LEVEL); end
        STALL = 1'b0;
        @(negedge CLK);
        INSTR_VALID = 1'b0;
        n_cmp++; if ({REDIRECT, LEVEL} !== {1'b0, 3'd0}) begin n_err++; $display("FAIL stall_pop: got redirect %0b level %0d, expected 0 0", REDIRECT, LEVEL); end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL stall_missing: got %0d left, expected 0", sb.size()); end
    endtask

    task automatic test_wrap();
        do_reset();
        issue(CNT_IMM, 24'd0, 16'h0);
        issue(START, 24'd0, 16'hFFFF);
        issue(ENDL, 24'd0, 16'h0);
        idle();
        n_cmp++; if ({REDIRECT, LEVEL} !== {1'b0, 3'd0}) begin n_err++; $display("FAIL count0: got redirect %0b level %0d, expected 0 0", REDIRECT, LEVEL); end
        issue(CNT_IMM, 24'd2, 16'h1);
        issue(START, 24'd0, 16'hFFFF);
        sb.push_back(16'h0);
        issue(ENDL, 24'd0, 16'h0);
        idle();
        n_cmp++; if ({REDIRECT, REDIRECT_PC} !== {1'b1, 16'h0}) begin n_err++; $display("FAIL wrap_pc: got redirect %0b pc %0h, expected 1 0", REDIRECT, REDIRECT_PC); end
        issue(ENDL, 24'd0, 16'h0);
        idle();
        n_cmp++; if (LEVEL !== 3'd0) begin n_err++; $display("FAIL wrap_level: got %0d, expected 0", LEVEL); end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL wrap_missing: got %0d left, expected 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue(CNT_IMM, 24'd3, 16'd0);
        issue(START, 24'd0, 16'd1);
        issue(CNT_IMM, 24'd3, 16'd2);
        issue(START, 24'd0, 16'd3);
        sb.push_back(16'd4);
        issue(ENDL, 24'd0, 16'd5);
        idle();
        n_cmp++; if ({REDIRECT, LEVEL} !== {1'b1, 3'd2}) begin n_err++; $display("FAIL mid_pre: got redirect %0b level %0d, expected 1 2", REDIRECT, LEVEL); end
        #2 RESET = 1'b1;
        #1;
        n_cmp++; if ({REDIRECT, REDIRECT_PC} !== 17'h0) begin n_err++; $display("FAIL mid_redirect: got %0b/%0h, expected 0/0", REDIRECT, REDIRECT_PC); end
        n_cmp++; if ({LEVEL, OVERFLOW, UNDERFLOW} !== 5'h0) begin n_err++; $display("FAIL mid_state: got level %0d flags %b, expected 0 00", LEVEL, {OVERFLOW, UNDERFLOW}); end
        n_cmp++; if (TOTAL_ITER !== 32'h0) begin n_err++; $display("FAIL mid_total: got %0d, expected 0", TOTAL_ITER); end
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_cmp++; if ({REDIRECT, LEVEL} !== {1'b0, 3'd0}) begin n_err++; $display("FAIL mid_after: got redirect %0b level %0d, expected 0 0", REDIRECT, LEVEL); end
        end
        // With pending back at 1 the next loop body runs once and never redirects.
        issue(START, 24'd0, 16'd30);
        issue(ENDL, 24'd0, 16'd31);
        idle();
        n_cmp++; if ({REDIRECT, LEVEL} !== {1'b0, 3'd0}) begin n_err++; $display("FAIL mid_pending: got redirect %0b level %0d, expected 0 0", REDIRECT, LEVEL); end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL mid_missing: got %0d left, expected 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_nest();
        test_stack_limits();
        test_stall();
        test_wrap();
        test_reset_mid();
        repeat (2) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
